// File: rtl/mm_job_scheduler_pkg.sv
// Shared types and helpers for the matrix-multiplier job scheduler.
package mm_job_scheduler_pkg;

    // Scheduler phases, from ownership hand-out to result readback.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_BUSY,
        ST_DRAIN,
        ST_RECOVER
    } sched_state_e;

    // Round-robin successor of a requester index (wraps at n).
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mm_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scan upward from rr_ptr with wrap; the first set request wins.
    always_comb begin
        int k;
        // NOTE: every output gets a default before the scan so no path leaves one unassigned (no latch).
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!any && req[k]) begin
                any       = 1'b1;
                idx       = IW'(k);
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// Shares one matrix-multiplier core and its single-port BRAM among N_REQ requesters.
// Round-robin ownership, start/done handshake with the core, watchdog recovery.
module mm_job_scheduler
    import mm_job_scheduler_pkg::*;
#(
    parameter  int L_RAM_SIZE = 3,
    parameter  int BITWIDTH   = 32,
    parameter  int N_REQ      = 4,
    parameter  int TIMEOUT    = 4096,
    parameter  int RST_CYCLES = 2,
    localparam int AW         = 2 * L_RAM_SIZE + 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          go,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          cmp,
    output logic                      err,
    input  logic [N_REQ*AW-1:0]       req_addr,
    input  logic [N_REQ*BITWIDTH-1:0] req_wrdata,
    input  logic [N_REQ-1:0]          req_we,
    output logic [AW-1:0]             bram_addr,
    output logic [BITWIDTH-1:0]       bram_wrdata,
    output logic                      bram_we,
    input  logic [AW-1:0]             mm_addr,
    input  logic [BITWIDTH-1:0]       mm_wrdata,
    input  logic                      mm_we,
    output logic                      mm_start,
    output logic                      mm_reset,
    input  logic                      mm_done
);

    localparam int IW  = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT);
    localparam int RCW = $clog2(RST_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);

    sched_state_e     state_q, state_nx;
    logic [N_REQ-1:0] grant_q, cmp_q;
    logic             err_q;
    logic [IW-1:0]    g_idx, rr_ptr;
    logic [WDW-1:0]   wd_cnt;
    logic [RCW-1:0]   rst_cnt;
    logic             cmp_set, err_set;
    logic [N_REQ-1:0] arb_onehot;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign grant = grant_q;
    assign cmp   = cmp_q;
    assign err   = err_q;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_nx;
    end

    // Next-state logic; also flags the cycles that end a job with a cmp (and err) pulse.
    always_comb begin
        state_nx = state_q;
        cmp_set  = 1'b0;
        err_set  = 1'b0;
        unique case (state_q)
            ST_IDLE:    if (arb_any) state_nx = ST_GRANT;
            // A dropped request wins over a same-cycle go; go waits out the previous job's done tail.
            ST_GRANT: begin
                if (!req[g_idx])                  state_nx = ST_IDLE;
                else if (go[g_idx] && !mm_done)   state_nx = ST_START;
            end
            ST_START:   state_nx = ST_BUSY;
            ST_BUSY: begin
                if (mm_done) begin
                    state_nx = ST_DRAIN;
                    cmp_set  = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    state_nx = ST_RECOVER;
                end
            end
            ST_DRAIN:   if (!req[g_idx]) state_nx = ST_IDLE;
            ST_RECOVER: begin
                if (rst_cnt == RC_LAST) begin
                    state_nx = ST_DRAIN;
                    cmp_set  = 1'b1;
                    err_set  = 1'b1;
                end
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Grant/pointer bookkeeping, watchdog, recovery timer and the completion pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
            rst_cnt <= '0;
            cmp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && arb_any) begin
                grant_q <= arb_onehot;
                g_idx   <= arb_idx;
                rr_ptr  <= IW'(rr_next(int'(arb_idx), N_REQ));
            end else if (state_nx == ST_IDLE) begin
                grant_q <= '0;
            end

            // Watchdog restarts at START and saturates at its last value while BUSY.
            if (state_q == ST_START)
                wd_cnt <= '0;
            else if (state_q == ST_BUSY && wd_cnt != WD_LAST)
                wd_cnt <= wd_cnt + WDW'(1);

            if (state_q == ST_RECOVER) rst_cnt <= rst_cnt + RCW'(1);
            else                       rst_cnt <= '0;

            cmp_q <= cmp_set ? grant_q : '0;
            err_q <= err_set;
        end
    end

    // Core control strobes and the BRAM port mux (grantee while loading/reading, core while running).
    always_comb begin
        mm_start    = (state_q == ST_START);
        mm_reset    = !aresetn || (state_q == ST_RECOVER);
        bram_addr   = '0;
        bram_wrdata = '0;
        bram_we     = 1'b0;
        unique case (state_q)
            ST_GRANT, ST_DRAIN: begin
                bram_addr   = req_addr[int'(g_idx)*AW +: AW];
                bram_wrdata = req_wrdata[int'(g_idx)*BITWIDTH +: BITWIDTH];
                bram_we     = req_we[g_idx];
            end
            ST_START, ST_BUSY: begin
                bram_addr   = mm_addr;
                bram_wrdata = mm_wrdata;
                bram_we     = mm_we;
            end
            // Core is being reset: keep its address on the port but never let it write.
            ST_RECOVER: begin
                bram_addr   = mm_addr;
                bram_wrdata = mm_wrdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Self-checking bench for mm_job_scheduler: directed scenarios, a job-level reference model
// compared on every cycle, a mock mm core and a BRAM model.
module tb_mm_job_scheduler;

    localparam int N  = 4;
    localparam int LR = 3;
    localparam int AW = 2 * LR + 1;
    localparam int BW = 32;
    localparam int TO = 64;
    localparam int RC = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;

    logic [N-1:0]    req  = '0;
    logic [N-1:0]    go   = '0;
    logic [N-1:0]    r_we = '0;
    logic [AW-1:0]   r_addr [N];
    logic [BW-1:0]   r_data [N];
    logic [N*AW-1:0] req_addr;
    logic [N*BW-1:0] req_wrdata;

    logic [N-1:0]  grant, cmp;
    logic          err;
    logic [AW-1:0] bram_addr;
    logic [BW-1:0] bram_wrdata;
    logic          bram_we;
    logic [AW-1:0] mm_addr   = '0;
    logic [BW-1:0] mm_wrdata = '0;
    logic          mm_we     = 1'b0;
    logic          mm_done   = 1'b0;
    logic          mm_start, mm_reset;

    int checks = 0;
    int errors = 0;

    mm_job_scheduler #(
        .L_RAM_SIZE (LR), .BITWIDTH (BW), .N_REQ (N), .TIMEOUT (TO), .RST_CYCLES (RC)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req         (req),
        .go          (go),
        .grant       (grant),
        .cmp         (cmp),
        .err         (err),
        .req_addr    (req_addr),
        .req_wrdata  (req_wrdata),
        .req_we      (r_we),
        .bram_addr   (bram_addr),
        .bram_wrdata (bram_wrdata),
        .bram_we     (bram_we),
        .mm_addr     (mm_addr),
        .mm_wrdata   (mm_wrdata),
        .mm_we       (mm_we),
        .mm_start    (mm_start),
        .mm_reset    (mm_reset),
        .mm_done     (mm_done)
    );

    always #5 aclk = ~aclk;

    // Flatten per-requester address/data into the DUT buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]   = r_addr[i];
            req_wrdata[i*BW +: BW] = r_data[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // ---------------- mock mm core and BRAM ----------------
    logic          core_start_s = 1'b0, core_reset_s = 1'b0, core_hang = 1'b0;
    int            core_cnt = -1;
    int            job_id   = 0;
    logic [BW-1:0] mem [128];
    logic          bw_s = 1'b0;
    logic [AW-1:0] ba_s = '0;
    logic [BW-1:0] bd_s = '0;

    // Sample DUT outputs mid-cycle for the mock core and BRAM.
    always @(negedge aclk) begin
        core_start_s <= mm_start;
        core_reset_s <= mm_reset;
        bw_s         <= bram_we;
        ba_s         <= bram_addr;
        bd_s         <= bram_wrdata;
    end

    // Mock core: done 20 cycles after start, held 5; writes its job tag to word 127 at cycle 5.
    always @(posedge aclk) begin
        if (core_reset_s) begin
            core_cnt <= -1;
            mm_done  <= 1'b0;
            mm_we    <= 1'b0;
        end else if (core_start_s) begin
            core_cnt <= 0;
            job_id   <= job_id + 1;
            mm_done  <= 1'b0;
            mm_we    <= 1'b0;
            mm_addr  <= '0;
        end else if (core_cnt >= 0) begin
            core_cnt  <= (!core_hang && core_cnt + 1 >= 25) ? -1 : core_cnt + 1;
            mm_done   <= !core_hang && (core_cnt + 1 >= 20) && (core_cnt + 1 < 25);
            mm_we     <= (core_cnt + 1 == 5);
            mm_addr   <= (core_cnt + 1 == 5) ? AW'(127) : AW'(core_cnt + 1);
            mm_wrdata <= 32'hC0DE_0000 + BW'(job_id);
        end
    end

    // BRAM model: one write port fed by the scheduler.
    always @(posedge aclk) begin
        if (bw_s) mem[ba_s] <= bd_s;
    end

    // ---------------- job-level reference model ----------------
    typedef enum {P_FREE, P_OWNED, P_LAUNCH, P_RUN, P_RESET, P_READ} phase_e;
    phase_e m_phase    = P_FREE;
    int     m_owner    = -1;
    int     m_next     = 0;
    int     m_run      = 0;
    int     m_rst_left = 0;
    bit     m_cmp      = 1'b0;
    bit     m_err      = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] r, input int from);
        for (int i = 0; i < N; i++)
            if (r[(from + i) % N]) return (from + i) % N;
        return -1;
    endfunction

    // Advance the model one clock using the inputs seen at the edge.
    always @(posedge aclk or negedge aresetn) begin
        int w;
        w = rr_pick(req, m_next);
        if (!aresetn) begin
            m_phase <= P_FREE; m_owner <= -1; m_next <= 0;
            m_run <= 0; m_rst_left <= 0; m_cmp <= 1'b0; m_err <= 1'b0;
        end else begin
            m_cmp <= 1'b0;
            m_err <= 1'b0;
            case (m_phase)
                P_FREE: if (w >= 0) begin
                    m_owner <= w;
                    m_next  <= (w + 1) % N;
                    m_phase <= P_OWNED;
                end
                P_OWNED: begin
                    if (!req[m_owner]) begin
                        m_phase <= P_FREE; m_owner <= -1;
                    end else if (go[m_owner] && !mm_done) begin
                        m_phase <= P_LAUNCH;
                    end
                end
                P_LAUNCH: begin m_phase <= P_RUN; m_run <= 0; end
                P_RUN: begin
                    if (mm_done) begin
                        m_phase <= P_READ; m_cmp <= 1'b1;
                    end else if (m_run + 1 >= TO) begin
                        m_phase <= P_RESET; m_rst_left <= RC;
                    end else begin
                        m_run <= m_run + 1;
                    end
                end
                P_RESET: begin
                    if (m_rst_left == 1) begin
                        m_phase <= P_READ; m_cmp <= 1'b1; m_err <= 1'b1;
                    end else begin
                        m_rst_left <= m_rst_left - 1;
                    end
                end
                P_READ: if (!req[m_owner]) begin m_phase <= P_FREE; m_owner <= -1; end
                default: m_phase <= P_FREE;
            endcase
        end
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge aclk) begin
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("grant", grant, eg);
        check("cmp", cmp, m_cmp ? eg : '0);
        check("err", err, m_err);
        check("mm_start", mm_start, m_phase == P_LAUNCH);
        check("mm_reset", mm_reset, !aresetn || m_phase == P_RESET);
        case (m_phase)
            P_OWNED, P_READ: begin
                check("bram_addr_req", bram_addr, r_addr[m_owner]);
                check("bram_wrdata_req", bram_wrdata, r_data[m_owner]);
                check("bram_we_req", bram_we, r_we[m_owner]);
            end
            P_LAUNCH, P_RUN: begin
                check("bram_addr_core", bram_addr, mm_addr);
                check("bram_wrdata_core", bram_wrdata, mm_wrdata);
                check("bram_we_core", bram_we, mm_we);
            end
            default: check("bram_we_idle", bram_we, 1'b0);
        endcase
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        int n;
        n = 0;
        while (grant == '0 && n < 20) begin tick; n++; end
        check(name, grant, exp);
    endtask

    task automatic wait_cmp(output logic [N-1:0] c, output logic e);
        int n;
        n = 0;
        while (cmp == '0 && n < 100) begin tick; n++; end
        c = cmp;
        e = err;
    endtask

    task automatic run_job(input int r, input logic [N-1:0] exp, input string tag);
        logic [N-1:0] c;
        logic         e;
        wait_grant(exp, {tag, "_grant"});
        go[r] = 1'b1;
        wait_cmp(c, e);
        check({tag, "_cmp"}, c, exp);
        check({tag, "_err"}, e, 1'b0);
        req[r] = 1'b0;
        go[r]  = 1'b0;
        tick;
    endtask

    initial begin
        logic [N-1:0] c;
        logic         e;
        int           n, n_cmp, n_err;

        for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
        for (int i = 0; i < 128; i++) mem[i] = '0;

        // Reset values while aresetn is low.
        #2 aresetn = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_mm_reset", mm_reset, 1);
        check("rst_mm_start", mm_start, 0);
        check("rst_cmp", cmp, 0);
        check("rst_err", err, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_wrdata", bram_wrdata, 0);
        repeat (3) tick;
        aresetn = 1'b1;
        #1;
        check("rel_mm_reset", mm_reset, 0);
        tick;

        // All four request together: served 0,1,2,3.
        req = 4'b1111;
        run_job(0, 4'b0001, "rr0");
        run_job(1, 4'b0010, "rr1");
        run_job(2, 4'b0100, "rr2");
        run_job(3, 4'b1000, "rr3");
        tick;
        // Pointer wrapped back to 0: requester 0 beats requester 3.
        req = 4'b1001;
        wait_grant(4'b0001, "wrap_grant");
        req = 4'b0000;
        tick;
        check("wrap_drop", grant, 0);
        tick;

        // Single requester loads 128 words, runs a job, reads back.
        req = 4'b0001;
        tick;
        check("t1_grant_lat", grant, 4'b0001);
        r_we[0] = 1'b1;
        for (int i = 0; i < 128; i++) begin
            r_addr[0] = AW'(i);
            r_data[0] = 32'hA000_0000 + BW'(i);
            tick;
        end
        r_we[0] = 1'b0;
        go[0]   = 1'b1;
        tick;
        check("t1_mm_start", mm_start, 1);
        tick;
        check("t1_mm_start_pulse", mm_start, 0);
        go[0] = 1'b0;
        n_cmp = 0; n_err = 0; c = '0;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (cmp != '0) begin n_cmp++; c = cmp; end
            if (err) n_err++;
        end
        check("t1_cmp_count", n_cmp, 1);
        check("t1_cmp_value", c, 4'b0001);
        check("t1_err_count", n_err, 0);
        check("t1_mem0", mem[0], 32'hA000_0000);
        check("t1_mem126", mem[126], 32'hA000_007E);
        check("t1_mem127_core", mem[127], 32'hC0DE_0005);
        req = 4'b0000;
        tick;
        check("t1_drop_lat", grant, 0);
        tick;

        // Request drop and go in the same GRANT cycle: no start.
        req = 4'b0100;
        tick;
        check("t3_grant", grant, 4'b0100);
        req[2] = 1'b0;
        go[2]  = 1'b1;
        tick;
        check("t3_grant_drop", grant, 0);
        check("t3_no_start", mm_start, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin tick; if (mm_start) n++; end
        check("t3_no_start_later", n, 0);
        go[2] = 1'b0;
        tick;

        // Hung core: 64 BUSY cycles, mm_reset for 2, then cmp+err together.
        core_hang = 1'b1;
        req = 4'b1000;
        wait_grant(4'b1000, "t4_grant");
        go[3] = 1'b1;
        tick;
        check("t4_mm_start", mm_start, 1);
        n = 0;
        while (!mm_reset && n < 100) begin tick; n++; end
        check("t4_start_to_reset", n, TO + 1);
        n = 0;
        while (mm_reset && n < 10) begin tick; n++; end
        check("t4_reset_len", n, RC);
        check("t4_cmp", cmp, 4'b1000);
        check("t4_err", err, 1);
        tick;
        check("t4_err_pulse", err, 0);
        req = 4'b0000; go = 4'b0000; core_hang = 1'b0;
        repeat (2) tick;

        // Only the grantee's write reaches the BRAM.
        req = 4'b0010;
        wait_grant(4'b0010, "t5_grant");
        r_we      = 4'b0111;
        r_addr[0] = AW'(5); r_data[0] = 32'hDEAD_0000;
        r_addr[2] = AW'(5); r_data[2] = 32'hDEAD_0002;
        r_addr[1] = AW'(9); r_data[1] = 32'hBEEF_0009;
        tick;
        r_we = 4'b0000;
        tick;
        check("t5_mem5_kept", mem[5], 32'hA000_0005);
        check("t5_mem9_grantee", mem[9], 32'hBEEF_0009);
        req = 4'b0000;
        repeat (2) tick;

        // Reset in the middle of a job.
        req = 4'b0100;
        wait_grant(4'b0100, "t6_grant");
        go[2] = 1'b1;
        repeat (6) tick;
        aresetn = 1'b0;
        #1;
        check("t6_grant", grant, 0);
        check("t6_mm_reset", mm_reset, 1);
        check("t6_mm_start", mm_start, 0);
        check("t6_cmp", cmp, 0);
        req = 4'b0000; go = 4'b0000;
        repeat (3) tick;
        aresetn = 1'b1;
        #1;
        check("t6_rel_grant", grant, 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin tick; if (cmp != '0) n++; end
        check("t6_no_cmp", n, 0);
        req = 4'b1111;
        tick;
        check("t6_ptr_reset", grant, 4'b0001);
        req = 4'b0000;
        repeat (4) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
